// File: rtl/riot_bus_master_pkg.sv
// riot_pkg: shared types and constants for the RRIOT bus initiator.
//   riot_op_e    : command opcodes carried on the command channel
//   riot_state_e : bus-sequencer FSM states
//   RIOT_*       : peripheral register addresses (timer writes / reads)
package riot_pkg;

  typedef enum logic [1:0] {
    OP_WRITE    = 2'd0,
    OP_READ     = 2'd1,
    OP_WAIT_IRQ = 2'd2,
    OP_RSVD     = 2'd3
  } riot_op_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR       = 3'd1,
    ST_RD_ADDR  = 3'd2,
    ST_RD_WAIT  = 3'd3,
    ST_WAIT_IRQ = 3'd4,
    ST_RESP     = 3'd5
  } riot_state_e;

  localparam logic [2:0] RIOT_WR_DIV1    = 3'b100;
  localparam logic [2:0] RIOT_WR_DIV8    = 3'b101;
  localparam logic [2:0] RIOT_WR_DIV64   = 3'b110;
  localparam logic [2:0] RIOT_WR_DIV1024 = 3'b111;
  localparam logic [2:0] RIOT_RD_TIMER   = 3'b000;
  localparam logic [2:0] RIOT_RD_FLAG    = 3'b001;

endpackage

// File: rtl/riot_bus_master_if.sv
// riot_bus_master_if: command channel, response channel and peripheral bus
// of the RRIOT bus initiator.
//   master : the bus initiator's view (consumes commands, drives bus)
//   slave  : controller + peripheral view (issues commands, answers bus)
interface riot_bus_master_if;
  import riot_pkg::*;

  logic       cmd_valid;
  logic       cmd_ready;
  riot_op_e   cmd_op;
  logic [2:0] cmd_addr;
  logic [7:0] cmd_data;

  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_err;

  logic       bus_we_n;
  logic [2:0] bus_addr;
  logic [7:0] bus_di;
  logic [7:0] bus_do;
  logic       bus_oe;
  logic       bus_irq_n;

  modport master (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
           bus_do, bus_oe, bus_irq_n,
    output cmd_ready, rsp_valid, rsp_data, rsp_err,
           bus_we_n, bus_addr, bus_di
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
           bus_do, bus_oe, bus_irq_n,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err,
           bus_we_n, bus_addr, bus_di
  );

endinterface

// File: rtl/riot_bus_master.sv
// riot_bus_master: sequences 6530-style RRIOT register bus cycles from
// byte-level commands and returns one response per command.
//   clk, rst : single clock, synchronous active-high reset
//   io       : riot_bus_master_if.master (command, response, peripheral bus)
// All outputs are registered; bus_do / bus_irq_n are same-domain inputs.
//
// state       | meaning
// ------------+--------------------------------------------------------
// ST_IDLE     | cmd_ready high, bus parked at IDLE_ADDR
// ST_WR       | one cycle with bus_we_n low, addr/data on the bus
// ST_RD_ADDR  | read address presented, strobe high
// ST_RD_WAIT  | address held READ_LAT cycles; bus_do captured at last edge
// ST_WAIT_IRQ | bus idle, waiting for bus_irq_n low or the timeout
// ST_RESP     | rsp_valid high, payload held until rsp_ready
module riot_bus_master
  import riot_pkg::*;
#(
  parameter int unsigned READ_LAT     = 1,
  parameter logic [2:0]  IDLE_ADDR    = 3'b101,
  parameter logic [15:0] WAIT_TIMEOUT = 16'd65535
) (
  input logic              clk,
  input logic              rst,
  riot_bus_master_if.master io
);

  localparam logic [15:0] RD_LAST = 16'(READ_LAT - 1);
  localparam logic [15:0] TO_LAST = WAIT_TIMEOUT - 16'd1;
  localparam bit          TO_EN   = (WAIT_TIMEOUT != 16'd0);

  riot_state_e state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [7:0]  rsp_data_q, rsp_data_d;
  logic        rsp_err_q, rsp_err_d;
  logic        we_n_q, we_n_d;
  logic [2:0]  addr_q, addr_d;
  logic [7:0]  di_q, di_d;

  // bus_oe is observed only; it plays no part in sequencing.
  logic unused_oe;
  assign unused_oe = io.bus_oe;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      we_n_q      <= 1'b1;
      addr_q      <= IDLE_ADDR;
      di_q        <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      we_n_q      <= we_n_d;
      addr_q      <= addr_d;
      di_q        <= di_d;
    end
  end

  // Command fields are latched straight into the bus registers, which
  // hold them for the whole bus cycle; no separate command copy is kept.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    we_n_d      = 1'b1;
    addr_d      = addr_q;
    di_d        = di_q;

    case (state_q)
      ST_IDLE: begin
        cmd_ready_d = 1'b1;
        if (io.cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          cnt_d       = '0;
          case (io.cmd_op)
            OP_WRITE: begin
              state_d = ST_WR;
              we_n_d  = 1'b0;
              addr_d  = io.cmd_addr;
              di_d    = io.cmd_data;
            end
            OP_READ: begin
              state_d = ST_RD_ADDR;
              addr_d  = io.cmd_addr;
            end
            OP_WAIT_IRQ: state_d = ST_WAIT_IRQ;
            default: begin
              state_d     = ST_RESP;
              rsp_valid_d = 1'b1;
              rsp_data_d  = '0;
              rsp_err_d   = 1'b1;
            end
          endcase
        end
      end
      ST_WR: begin
        state_d     = ST_RESP;
        addr_d      = IDLE_ADDR;
        rsp_valid_d = 1'b1;
        rsp_data_d  = di_q;
        rsp_err_d   = 1'b0;
      end
      ST_RD_ADDR: begin
        state_d = ST_RD_WAIT;
        cnt_d   = '0;
      end
      ST_RD_WAIT: begin
        if (cnt_q == RD_LAST) begin
          state_d     = ST_RESP;
          cnt_d       = '0;
          addr_d      = IDLE_ADDR;
          rsp_valid_d = 1'b1;
          rsp_data_d  = io.bus_do;
          rsp_err_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_WAIT_IRQ: begin
        // irq wins over a timeout landing in the same cycle
        if (!io.bus_irq_n) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_data_d  = '0;
          rsp_err_d   = 1'b0;
        end else if (TO_EN && (cnt_q == TO_LAST)) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
        end else if (TO_EN) begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_RESP: begin
        if (io.rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign io.cmd_ready = cmd_ready_q;
  assign io.rsp_valid = rsp_valid_q;
  assign io.rsp_data  = rsp_data_q;
  assign io.rsp_err   = rsp_err_q;
  assign io.bus_we_n  = we_n_q;
  assign io.bus_addr  = addr_q;
  assign io.bus_di    = di_q;

endmodule

// File: tb/tb_riot_bus_master.sv
// Bench for riot_bus_master: directed and random commands against a
// transaction-level reference model, plus a small behavioural timer for the
// system-level WAIT_IRQ / flag read sequence.
module tb_riot_bus_master;
  import riot_pkg::*;

  localparam int          RL     = 1;
  localparam int          TMO    = 20;
  localparam logic [2:0]  IDLE_A = 3'b101;

  logic clk;
  logic rst;
  riot_bus_master_if io ();

  riot_bus_master #(
    .READ_LAT    (RL),
    .IDLE_ADDR   (IDLE_A),
    .WAIT_TIMEOUT(16'(TMO))
  ) dut (
    .clk(clk),
    .rst(rst),
    .io (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- peripheral model ----------------
  logic       sys_mode = 1'b0;
  logic       irq_drv  = 1'b1;
  logic [7:0] pmem [8];
  logic [7:0] do_q = 8'h00;
  logic [7:0] tmr = 8'h00;
  logic [10:0] pre = 11'd0;
  logic [10:0] div_m1 = 11'd0;
  logic       run = 1'b0;
  logic       flag = 1'b0;

  function automatic logic [10:0] div_of(input logic [1:0] sel);
    case (sel)
      2'd0: return 11'd0;
      2'd1: return 11'd7;
      2'd2: return 11'd63;
      default: return 11'd1023;
    endcase
  endfunction

  always @(posedge clk) begin
    if (sys_mode) begin
      if (!io.bus_we_n && io.bus_addr[2]) begin
        tmr    <= io.bus_di;
        pre    <= div_of(io.bus_addr[1:0]);
        div_m1 <= div_of(io.bus_addr[1:0]);
        run    <= 1'b1;
        flag   <= 1'b0;
      end else if (run && !flag) begin
        if (pre == 11'd0) begin
          pre <= div_m1;
          if (tmr == 8'd0) flag <= 1'b1;
          else tmr <= tmr - 8'd1;
        end else begin
          pre <= pre - 11'd1;
        end
      end
      do_q <= (io.bus_addr == RIOT_RD_FLAG) ? {7'd0, flag} : tmr;
    end else begin
      if (!io.bus_we_n) pmem[io.bus_addr] <= io.bus_di;
      do_q <= pmem[io.bus_addr];
    end
  end

  assign io.bus_do    = do_q;
  assign io.bus_oe    = io.bus_we_n & ~io.bus_addr[2];
  assign io.bus_irq_n = sys_mode ? ~flag : irq_drv;

  // write-strobe monitor
  int         we_tot = 0;
  logic [2:0] we_addr = 3'd0;
  logic [7:0] we_di = 8'd0;
  always @(negedge clk) begin
    if (io.bus_we_n === 1'b0) begin
      we_tot  = we_tot + 1;
      we_addr = io.bus_addr;
      we_di   = io.bus_di;
    end
  end

  // ---------------- reference model ----------------
  // Register file as seen by the controller; response and latency (cycles
  // from the handshake cycle to the first rsp_valid cycle) per command.
  int ref_mem [8];

  function automatic void model(input int op, input int a, input int d, input int irq_d,
                                output int ed, output int ee, output int el);
    ed = 0; ee = 0; el = 0;
    case (op)
      0: begin ed = d; el = 1; ref_mem[a] = d; end
      1: begin ed = ref_mem[a]; el = RL + 1; end
      2: begin
        if (irq_d < TMO) el = irq_d + 1;
        else begin ee = 1; el = TMO; end
      end
      default: ee = 1;
    endcase
  endfunction

  task automatic run_cmd(input int op, input int a, input int d, input int irq_d, input int bp,
                         input bit do_chk, output int g_data, output int g_err, output int g_lat);
    int ed, ee, el, k, n, we_base;
    ed = 0; ee = 0; el = 0;
    g_data = 0; g_err = 0; g_lat = 0;
    if (do_chk) model(op, a, d, irq_d, ed, ee, el);
    io.cmd_valid = 1'b1;
    io.cmd_op    = riot_op_e'(op[1:0]);
    io.cmd_addr  = a[2:0];
    io.cmd_data  = d[7:0];
    n = 0;
    while (io.cmd_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      chk("cmd_accept_timeout", 32'(n), 32'd0);
      io.cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    we_base = we_tot;
    @(negedge clk);
    io.cmd_valid = 1'b0;
    if (do_chk) chk("bus_addr_cycle0", 32'(io.bus_addr), (op == 0 || op == 1) ? 32'(a) : 32'(IDLE_A));
    k = 0;
    while (io.rsp_valid !== 1'b1 && k < 100) begin
      if (op == 2 && k >= irq_d) irq_drv = 1'b0;
      @(negedge clk);
      k++;
    end
    irq_drv = 1'b1;
    if (k >= 100) begin
      chk("rsp_timeout", 32'(k), 32'd0);
      return;
    end
    g_lat  = k;
    g_data = int'(io.rsp_data);
    g_err  = int'(io.rsp_err);
    if (do_chk) begin
      chk("rsp_latency", 32'(k), 32'(el));
      chk("rsp_data", 32'(io.rsp_data), 32'(ed));
      chk("rsp_err", 32'(io.rsp_err), 32'(ee));
      chk("we_strobes", 32'(we_tot - we_base), (op == 0) ? 32'd1 : 32'd0);
      if (op == 0) begin
        chk("we_addr", 32'(we_addr), 32'(a));
        chk("we_di", 32'(we_di), 32'(d));
      end
    end
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      if (do_chk)
        chk("rsp_hold", 32'({io.rsp_valid, io.cmd_ready, io.rsp_err, io.rsp_data}),
            32'({1'b1, 1'b0, ee[0], ed[7:0]}));
    end
    io.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    io.rsp_ready = 1'b0;
    chk("rsp_drop", 32'(io.rsp_valid), 32'd0);
    chk("cmd_ready_back", 32'(io.cmd_ready), 32'd1);
    chk("bus_park", 32'({io.bus_we_n, io.bus_addr}), 32'({1'b1, IDLE_A}));
  endtask

  // Reset asserted `cyc` cycles after the handshake cycle of a command.
  task automatic rst_mid(input int op, input int a, input int d, input int cyc);
    int n;
    io.cmd_valid = 1'b1;
    io.cmd_op    = riot_op_e'(op[1:0]);
    io.cmd_addr  = a[2:0];
    io.cmd_data  = d[7:0];
    n = 0;
    while (io.cmd_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    io.cmd_valid = 1'b0;
    repeat (cyc) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_we_n", 32'(io.bus_we_n), 32'd1);
    chk("rst_bus_addr", 32'(io.bus_addr), 32'(IDLE_A));
    chk("rst_rsp_valid", 32'(io.rsp_valid), 32'd0);
    chk("rst_cmd_ready", 32'(io.cmd_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_release_ready", 32'(io.cmd_ready), 32'd1);
    @(negedge clk);
    chk("rst_no_rsp", 32'(io.rsp_valid), 32'd0);
  endtask

  int gd, ge, gl, total, op, a, d, dly, sel;

  initial begin
    io.cmd_valid = 1'b0;
    io.cmd_op    = OP_WRITE;
    io.cmd_addr  = 3'd0;
    io.cmd_data  = 8'd0;
    io.rsp_ready = 1'b0;
    for (int i = 0; i < 8; i++) ref_mem[i] = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outputs",
        32'({io.cmd_ready, io.rsp_valid, io.rsp_err, io.bus_we_n, io.bus_addr, io.rsp_data, io.bus_di}),
        32'({1'b0, 1'b0, 1'b0, 1'b1, IDLE_A, 8'h00, 8'h00}));
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 32'(io.cmd_ready), 32'd1);

    // directed: write, then populate every register so reads are defined
    run_cmd(0, 5, 8'h10, 0, 0, 1, gd, ge, gl);
    for (int i = 0; i < 8; i++)
      run_cmd(0, i, (i == 0) ? 8'h3C : int'($urandom_range(0, 255)), 0, 0, 1, gd, ge, gl);
    run_cmd(1, 0, 0, 0, 0, 1, gd, ge, gl);

    // WAIT_IRQ: irq after 7, never, immediate, and both sides of the limit
    run_cmd(2, 0, 0, 7, 0, 1, gd, ge, gl);
    run_cmd(2, 0, 0, 1000, 0, 1, gd, ge, gl);
    run_cmd(2, 0, 0, 0, 0, 1, gd, ge, gl);
    run_cmd(2, 0, 0, TMO - 1, 0, 1, gd, ge, gl);
    run_cmd(2, 0, 0, TMO, 0, 1, gd, ge, gl);

    // reserved opcode with response back-pressure
    run_cmd(3, 2, 8'hA5, 0, 5, 1, gd, ge, gl);

    // reset during RD_WAIT, then during WR (the strobe was already on the bus)
    rst_mid(1, 3, 0, 1);
    run_cmd(1, 3, 0, 0, 0, 1, gd, ge, gl);
    rst_mid(0, 6, 8'h5A, 0);
    ref_mem[6] = 8'h5A;
    run_cmd(1, 6, 0, 0, 0, 1, gd, ge, gl);

    // random traffic
    for (int n = 0; n < 60; n++) begin
      op  = int'($urandom_range(0, 3));
      a   = int'($urandom_range(0, 7));
      d   = int'($urandom_range(0, 255));
      sel = int'($urandom_range(0, 4));
      case (sel)
        0: dly = 0;
        1: dly = TMO - 1;
        2: dly = TMO;
        3: dly = 1000;
        default: dly = int'($urandom_range(0, 30));
      endcase
      run_cmd(op, a, d, dly, int'($urandom_range(0, 3)), 1, gd, ge, gl);
    end

    // system sequence with the behavioural timer: DIV8 load of 4, wait, flag
    sys_mode = 1'b1;
    run_cmd(0, int'(RIOT_WR_DIV8), 8'h04, 0, 0, 1, gd, ge, gl);
    total = gl + 2;
    ge = 1;
    for (int t = 0; t < 4 && ge != 0; t++) begin
      run_cmd(2, 0, 0, 1000, 0, 0, gd, ge, gl);
      total += gl + 2;
    end
    chk("sys_irq_err", 32'(ge), 32'd0);
    chk("sys_irq_within_48", 32'(total <= 48), 32'd1);
    run_cmd(1, int'(RIOT_RD_FLAG), 0, 0, 0, 0, gd, ge, gl);
    chk("sys_flag_bit0", 32'(gd & 1), 32'd1);
    chk("sys_flag_err", 32'(ge), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
